// File: rtl/keyed_mux_key_loader.sv
// Serial key loader for key-locked c432 variants.
// Receives a parity-framed serial key and updates D atomically.
module keyed_mux_key_loader #(
  parameter int KEY_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             KEY_START,
  input  logic             KEY_BIT,
  input  logic             KEY_BIT_VLD,
  output logic             KEY_RDY,
  output logic [KEY_W-1:0] D,
  output logic             KEY_OK,
  output logic             LOAD_DONE,
  output logic             KEY_ERR,
  output logic             BUSY
);

  localparam int CW = $clog2(KEY_W + 2);
  localparam logic [CW-1:0] LAST = CW'(KEY_W);
  localparam logic [7:0] IDLE_MAX = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } state_t;

  state_t           state;
  logic [KEY_W-1:0] sr;
  logic [CW-1:0]    cnt;
  logic             par;
  logic [7:0]       idle;
  logic             take;

  // A bit is taken only while shifting; ready is a pure state decode.
  assign KEY_RDY = (state == SHIFT);
  assign take    = KEY_BIT_VLD && KEY_RDY;

  // Frame FSM: shift data bits, check parity, commit key atomically.
  always_ff @(posedge CK) begin
    if (RST) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      par       <= 1'b0;
      idle      <= '0;
      D         <= '0;
      KEY_OK    <= 1'b0;
      LOAD_DONE <= 1'b0;
      KEY_ERR   <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      LOAD_DONE <= 1'b0;
      KEY_ERR   <= 1'b0;
      if (KEY_START) begin
        state <= SHIFT;
        BUSY  <= 1'b1;
        sr    <= '0;
        cnt   <= '0;
        par   <= 1'b0;
        idle  <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            BUSY <= 1'b0;
          end
          SHIFT: begin
            if (take) begin
              par  <= par ^ KEY_BIT;
              idle <= '0;
              if (cnt == LAST) begin
                state <= CHECK;
              end else begin
                sr  <= (sr << 1) | KEY_W'(KEY_BIT);
                cnt <= cnt + 1'b1;
              end
            end else if (idle >= IDLE_MAX) begin
              KEY_ERR <= 1'b1;
              state   <= IDLE;
              BUSY    <= 1'b0;
            end else begin
              idle <= idle + 8'd1;
            end
          end
          CHECK: begin
            if (!par) begin
              D         <= sr;
              KEY_OK    <= 1'b1;
              LOAD_DONE <= 1'b1;
            end else begin
              KEY_ERR <= 1'b1;
            end
            state <= IDLE;
            BUSY  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
